if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and chip-enable, runs a req/ack transaction on the instruction bus (zero or more wait states), and raises a stall request while the bus is pending.
- Delivers {pc, inst} into the ID stage through an internal IF/ID register that honours pipeline stall, bubble and flush.
- Includes a one-entry hold buffer so a fetch that completes while ID is stalled is not lost.

---
 rtl/if_fetch_stage_pkg.sv | 9 +
 rtl/if_fetch_stage_if.sv | 12 +
 rtl/if_fetch_stage_hold_buf.sv | 52 +++++
 rtl/if_fetch_stage.sv | 105 ++++++++++
 tb/tb_if_fetch_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared FSM states, stop levels, bus widths and NOP word for the fetch stage
package if_fetch_stage_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} if_state_e;
    localparam logic STOP = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: req/ack instruction bus between the fetch stage and memory
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic req;
    logic [ADDR_W-1:0] addr;
    logic ack;
    logic [DATA_W-1:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// if_hold_buf: one-entry parking register for a fetch that completes while IF is stopped
module if_hold_buf
    import if_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              excp_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              excp_o
);
    logic valid_q, valid_d, excp_q, excp_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;

    // load wins over clear; an emptied entry reads back as a bubble
    always_comb begin
        valid_d = load ? 1'b1 : clear ? 1'b0 : valid_q;
        pc_d = load ? pc_i : clear ? '0 : pc_q;
        inst_d = load ? inst_i : clear ? NOP_INST : inst_q;
        excp_d = load ? excp_i : clear ? 1'b0 : excp_q;
    end

    // entry register
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q <= '0;
            inst_q <= NOP_INST;
            excp_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q <= pc_d;
            inst_q <= inst_d;
            excp_q <= excp_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o = pc_q;
    assign inst_o = inst_q;
    assign excp_o = excp_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: IF stage with req/ack instruction bus, stall request and IF/ID register; IF_ALIGN_CHECK_EN enables misaligned-fetch trapping
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    if_fetch_stage_if.master  ibus,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_excp_adel
);
    if_state_e state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d, id_pc_q, id_pc_d, fetch_addr, addr, hb_pc;
    logic [DATA_W-1:0] id_inst_q, id_inst_d, hb_inst;
    logic id_adel_q, id_adel_d, hb_excp, hb_valid;
    logic if_stop, id_stop, misalign, req, cap, rel, adel_ev;
    logic stall_unused;

    assign stall_unused = ^{stall[5:3], stall[0]};
    assign if_stop = stall[1] == STOP;
    assign id_stop = stall[2] == STOP;
`ifdef IF_ALIGN_CHECK_EN
    assign misalign = pc_i[1:0] != 2'b00;
    assign fetch_addr = pc_i;
    assign id_excp_adel = id_adel_q;
`else
    logic align_unused;
    assign align_unused = ^{pc_i[1:0], id_adel_q};
    assign misalign = 1'b0;
    assign fetch_addr = {pc_i[ADDR_W-1:2], 2'b00};
    assign id_excp_adel = 1'b0;
`endif

    assign req = !rst && (state_q == S_IDLE ? ce_i && !flush && !misalign : state_q != S_HOLD);
    assign addr = state_q == S_IDLE ? fetch_addr : req_addr_q;
    assign cap = req && ibus.ack && (state_q == S_IDLE || (state_q == S_WAIT && !flush));
    assign rel = state_q == S_HOLD && !if_stop && hb_valid;
    assign adel_ev = state_q == S_IDLE && ce_i && misalign && !if_stop;
    assign ibus.req = req;
    assign ibus.addr = addr;
    assign stallreq_o = req && !ibus.ack;
    assign id_pc = id_pc_q;
    assign id_inst = id_inst_q;

    if_hold_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INST(NOP_INST)) u_hold (
        .clk(clk),
        .rst(rst),
        .load(cap && if_stop),
        .clear(flush || rel),
        .pc_i(addr),
        .inst_i(ibus.rdata),
        .excp_i(1'b0),
        .valid_o(hb_valid),
        .pc_o(hb_pc),
        .inst_o(hb_inst),
        .excp_o(hb_excp)
    );

    // next state and IF/ID contents: flush, bubble, capture, release, misalign trap, else hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = cap && if_stop ? S_HOLD : req && !ibus.ack ? S_WAIT : S_IDLE;
            S_WAIT: state_d = cap && if_stop ? S_HOLD : ibus.ack ? S_IDLE : flush ? S_DRAIN : S_WAIT;
            S_HOLD: state_d = flush || !if_stop ? S_IDLE : S_HOLD;
            default: state_d = ibus.ack ? S_IDLE : S_DRAIN;
        endcase
        req_addr_d = state_q == S_IDLE && req ? fetch_addr : req_addr_q;
        {id_pc_d, id_inst_d, id_adel_d} = {id_pc_q, id_inst_q, id_adel_q};
        if (flush || (if_stop && !id_stop))
            {id_pc_d, id_inst_d, id_adel_d} = {{ADDR_W{1'b0}}, NOP_INST, 1'b0};
        else if (cap && !if_stop)
            {id_pc_d, id_inst_d, id_adel_d} = {addr, ibus.rdata, 1'b0};
        else if (rel)
            {id_pc_d, id_inst_d, id_adel_d} = {hb_pc, hb_inst, hb_excp};
        else if (adel_ev)
            {id_pc_d, id_inst_d, id_adel_d} = {pc_i, NOP_INST, 1'b1};
    end

    // state, held request address and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_addr_q <= '0;
            id_pc_q <= '0;
            id_inst_q <= NOP_INST;
            id_adel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_addr_q <= req_addr_d;
            id_pc_q <= id_pc_d;
            id_inst_q <= id_inst_d;
            id_adel_q <= id_adel_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for the fetch stage, directed cases then randomized traffic
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    typedef struct packed {logic req; logic [31:0] addr; logic stallreq;} bus_t;
    typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic adel;} idif_t;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ce_i = 1'b0;
    logic stallreq_o, id_excp_adel;
    logic [5:0] stall = 6'b0;
    logic [31:0] pc_i = 32'h0, id_pc, id_inst;
    int checks = 0, fails = 0, wait_n = 0, wl = 0;
    bus_t busq[$];
    idif_t idq[$];
    logic busy = 1'b0, dead = 1'b0, parked = 1'b0;
    logic [31:0] taddr = 32'h0, park_pc = 32'h0, park_inst = 32'h0;
    idif_t exp_id = '{32'h0, NOP, 1'b0};

    if_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) ibus ();

    if_fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .pc_i(pc_i),
        .ce_i(ce_i),
        .ibus(ibus),
        .stallreq_o(stallreq_o),
        .id_pc(id_pc),
        .id_inst(id_inst),
        .id_excp_adel(id_excp_adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus. The model thinks in transactions: an outstanding
    // fetch (possibly already squashed), a parked result waiting for IF to
    // resume, and the word ID should be holding after the edge.
    task automatic step(input logic r, input logic c, input logic [31:0] pc,
                        input logic [5:0] st, input logic fl, input logic [31:0] rd);
        logic mis, rq, ak, keep, s1, s2;
        logic [31:0] a;
        @(negedge clk);
        s1 = st[1];
        s2 = st[2];
        mis = ALIGN && pc[1:0] != 2'b00;
        a = busy ? taddr : (ALIGN ? pc : {pc[31:2], 2'b00});
        rq = !r && (busy || (!parked && c && !fl && !mis));
        if (rq && !busy) wl = wait_n;
        ak = rq && wl == 0;
        if (rq && !ak) wl--;
        rst = r;
        ce_i = c;
        pc_i = pc;
        stall = st;
        flush = fl;
        ibus.ack = ak;
        ibus.rdata = rd;
        busq.push_back('{rq, a, rq && !ak});
        if (r) begin
            busy = 1'b0;
            dead = 1'b0;
            parked = 1'b0;
            exp_id = '{32'h0, NOP, 1'b0};
        end else begin
            keep = ak && !(busy && (dead || fl));
            if (fl || (s1 && !s2)) exp_id = '{32'h0, NOP, 1'b0};
            else if (keep && !s1) exp_id = '{a, rd, 1'b0};
            else if (parked && !s1) exp_id = '{park_pc, park_inst, 1'b0};
            else if (!busy && !parked && c && mis && !s1) exp_id = '{pc, NOP, 1'b1};
            if (keep && s1) begin
                park_pc = a;
                park_inst = rd;
            end
            parked = (keep && s1) || (parked && s1 && !fl);
            dead = rq && !ak && (dead || fl);
            busy = rq && !ak;
            taddr = a;
        end
        idq.push_back(exp_id);
    endtask

    // bus-side outputs, compared mid-cycle once inputs have settled
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            #2;
            if (busq.size() > 0) begin
                e = busq.pop_front();
                chk("ibus_req", 32'(ibus.req), 32'(e.req));
                chk("stallreq_o", 32'(stallreq_o), 32'(e.stallreq));
                if (e.req) chk("ibus_addr", ibus.addr, e.addr);
            end
        end
    end

    // IF/ID register, compared just after each edge
    initial begin
        idif_t e;
        forever begin
            @(posedge clk);
            #1;
            if (idq.size() > 0) begin
                e = idq.pop_front();
                chk("id_pc", id_pc, e.pc);
                chk("id_inst", id_inst, e.inst);
                chk("id_excp_adel", 32'(id_excp_adel), 32'(e.adel));
            end
        end
    end

    initial begin
        logic [31:0] p;
        logic [5:0] s;
        ibus.ack = 1'b0;
        ibus.rdata = 32'h0;
        step(1, 0, 32'h0, 6'b0, 0, 32'h0);
        step(1, 0, 32'h0, 6'b0, 0, 32'h0);
        step(0, 0, 32'h0, 6'b0, 0, 32'h0);
        #1;
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_adel", 32'(id_excp_adel), 32'h0);
        chk("rst_req", 32'(ibus.req), 32'h0);
        chk("rst_stallreq", 32'(stallreq_o), 32'h0);
        wait_n = 0;
        step(0, 1, 32'h0, 6'b0, 0, 32'h3401_0001);
        step(0, 1, 32'h4, 6'b0, 0, 32'h3402_0002);
        #1;
        chk("zw_inst0", id_inst, 32'h3401_0001);
        chk("zw_stallreq", 32'(stallreq_o), 32'h0);
        step(0, 1, 32'h8, 6'b0, 0, 32'h3403_0003);
        #1;
        chk("zw_inst1", id_inst, 32'h3402_0002);
        step(0, 0, 32'hC, 6'b0, 0, 32'h0);
        #1;
        chk("zw_inst2", id_inst, 32'h3403_0003);
        wait_n = 2;
        step(0, 1, 32'h100, 6'b0, 0, 32'h0);
        #1;
        chk("w2_addr0", ibus.addr, 32'h100);
        chk("w2_stall0", 32'(stallreq_o), 32'h1);
        step(0, 1, 32'h100, 6'b0, 0, 32'h0);
        #1;
        chk("w2_addr1", ibus.addr, 32'h100);
        chk("w2_stall1", 32'(stallreq_o), 32'h1);
        step(0, 1, 32'h100, 6'b0, 0, 32'h2400_00FF);
        #1;
        chk("w2_addr2", ibus.addr, 32'h100);
        chk("w2_stall2", 32'(stallreq_o), 32'h0);
        step(0, 0, 32'h104, 6'b0, 0, 32'h0);
        #1;
        chk("w2_id_pc", id_pc, 32'h100);
        chk("w2_id_inst", id_inst, 32'h2400_00FF);
        wait_n = 0;
        step(0, 1, 32'h20, 6'b000111, 0, 32'hAAAA_0020);
        step(0, 1, 32'h24, 6'b000111, 0, 32'h0);
        #1;
        chk("hold_req", 32'(ibus.req), 32'h0);
        chk("hold_inst", id_inst, 32'h2400_00FF);
        step(0, 1, 32'h24, 6'b000111, 0, 32'h0);
        step(0, 1, 32'h24, 6'b0, 0, 32'h0);
        step(0, 0, 32'h24, 6'b0, 0, 32'h0);
        #1;
        chk("rel_pc", id_pc, 32'h20);
        chk("rel_inst", id_inst, 32'hAAAA_0020);
        wait_n = 3;
        step(0, 1, 32'h40, 6'b0, 0, 32'h0);
        step(0, 1, 32'h40, 6'b0, 1, 32'h0);
        step(0, 1, 32'h80, 6'b0, 0, 32'h0);
        #1;
        chk("drain_addr", ibus.addr, 32'h40);
        chk("drain_stallreq", 32'(stallreq_o), 32'h1);
        chk("drain_inst", id_inst, NOP);
        step(0, 1, 32'h80, 6'b0, 0, 32'hDEAD_0040);
        wait_n = 0;
        step(0, 1, 32'h80, 6'b0, 0, 32'h1111_0080);
        #1;
        chk("drain_discard", id_inst, NOP);
        chk("after_drain_addr", ibus.addr, 32'h80);
        step(0, 0, 32'h84, 6'b0, 0, 32'h0);
        #1;
        chk("after_drain_pc", id_pc, 32'h80);
        chk("after_drain_inst", id_inst, 32'h1111_0080);
        step(0, 0, 32'h84, 6'b000011, 0, 32'h0);
        step(0, 0, 32'h84, 6'b0, 0, 32'h0);
        #1;
        chk("bubble_inst", id_inst, NOP);
        chk("bubble_pc", id_pc, 32'h0);
        step(0, 1, 32'h300, 6'b0, 0, 32'h5555_0300);
        wait_n = 3;
        step(0, 1, 32'h304, 6'b0, 0, 32'h0);
        step(1, 1, 32'h304, 6'b0, 0, 32'h0);
        #1;
        chk("rst_wait_req", 32'(ibus.req), 32'h0);
        step(0, 0, 32'h304, 6'b0, 0, 32'h0);
        #1;
        chk("rst_wait_pc", id_pc, 32'h0);
        chk("rst_wait_inst", id_inst, NOP);
`ifdef IF_ALIGN_CHECK_EN
        wait_n = 0;
        step(0, 1, 32'h102, 6'b0, 0, 32'h0);
        #1;
        chk("adel_req", 32'(ibus.req), 32'h0);
        step(0, 0, 32'h102, 6'b0, 0, 32'h0);
        #1;
        chk("adel_flag", 32'(id_excp_adel), 32'h1);
        chk("adel_pc", id_pc, 32'h102);
        chk("adel_inst", id_inst, NOP);
`endif
        for (int i = 0; i < 1500; i++) begin
            wait_n = $urandom_range(0, 3);
            p = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
            s = 6'($urandom);
            s[1] = $urandom_range(0, 3) == 0;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, p, s,
                 $urandom_range(0, 11) == 0, $urandom);
        end
        step(0, 0, 32'h0, 6'b0, 0, 32'h0);
        @(posedge clk);
        #2;
        chk("busq_drained", 32'(busq.size()), 32'h0);
        chk("idq_drained", 32'(idq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
